// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the transmit FSM state encoding, the register offsets relative
// to the block base address and the bit positions inside STATUS.
package uart_pkg;

   // Transmit FSM states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // Register byte offsets from BASE
   localparam logic [31:0] REG_TXDATA = 32'd0;
   localparam logic [31:0] REG_STATUS = 32'd4;

   // STATUS bit positions; the occupancy field starts at STAT_COUNT_LSB.
   // Writing a 1 to STAT_OVF in STATUS clears the sticky overflow flag.
   localparam int STAT_BUSY      = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_OVF       = 2;
   localparam int STAT_COUNT_LSB = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset (control only)
//   push, wdata    write request and data; ignored when full unless a
//                  pop is accepted on the same edge
//   pop            read request; ignored when empty
//   rdata          head entry (combinational, valid while !empty)
//   full, empty    occupancy flags
//   count          occupancy, 0 .. 2**DEPTH_LOG2
module sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  push,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  pop,
   output logic [WIDTH-1:0]      rdata,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int                DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr;
   logic [DEPTH_LOG2-1:0] rptr;
   logic                  wr_en;
   logic                  rd_en;

   assign full  = (count == DEPTH_CNT);
   assign empty = (count == '0);
   assign rdata = mem[rptr];

   // A pop on the same edge frees a slot, so a push into a full FIFO
   // is still taken in that case.
   assign rd_en = pop & ~empty;
   assign wr_en = push & (~full | rd_en);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_en) wptr <= wptr + 1'b1;
         if (rd_en) rptr <= rptr + 1'b1;
         if (wr_en && !rd_en)
            count <= count + 1'b1;
         else if (!wr_en && rd_en)
            count <= count - 1'b1;
      end
   end

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the core data-memory bus.
// TXDATA (BASE) queues bytes into a FIFO; STATUS (BASE+4) reports
// busy/full/ovf/count and clears the sticky overflow flag on write.
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   mem_valid, mem_write   bus strobe and direction (1 = write)
//   mem_wmask, mem_wdata   byte enables and write data
//   mem_addr               byte address
//   mem_rdata              registered read data, 0 when not selected
//   tx                     serial output, idles high
module uart_tx_mmio
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE       = 32'h1000_0000,
   parameter int          CLKDIV     = 868,
   parameter int          DEPTH_LOG2 = 3
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        mem_valid,
   input  logic        mem_write,
   input  logic [3:0]  mem_wmask,
   input  logic [31:0] mem_wdata,
   input  logic [31:0] mem_addr,
   output logic [31:0] mem_rdata,
   output logic        tx
);

   localparam int                BAUD_W      = $clog2(CLKDIV);
   localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKDIV - 1);

   logic                  sel_txdata;
   logic                  sel_status;
   logic                  push_req;
   logic                  ovf_clr;
   logic                  drop;
   logic                  pop;
   logic                  busy;
   logic                  ovf;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [DEPTH_LOG2:0]   fifo_count;
   logic [7:0]            fifo_rdata;
   logic [1:0]            state;
   logic [BAUD_W-1:0]     baud;
   logic                  baud_zero;
   logic [2:0]            bit_idx;
   logic [7:0]            shift;
   logic [31:0]           status_word;
   logic                  unused_bus;

   assign unused_bus = ^{mem_wdata[31:8], mem_wmask[3:1]};

   // Address decode: full 32-bit compare, so misaligned hits are ignored
   assign sel_txdata = mem_valid && (mem_addr == BASE + REG_TXDATA);
   assign sel_status = mem_valid && (mem_addr == BASE + REG_STATUS);
   assign push_req   = sel_txdata & mem_write & mem_wmask[0];
   assign ovf_clr    = sel_status & mem_write & mem_wmask[0] & mem_wdata[STAT_OVF];
   assign drop       = push_req & fifo_full & ~pop;

   // The FSM takes the next byte either from IDLE or at the very end of a
   // stop bit, which gives gap-free back-to-back frames.
   assign baud_zero = (baud == '0);
   assign pop = ~fifo_empty &
                ((state == ST_IDLE) || ((state == ST_STOP) && baud_zero));

   sync_fifo #(
      .WIDTH      (8),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push_req),
      .wdata (mem_wdata[7:0]),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign busy = (state != ST_IDLE) | ~fifo_empty;

   always_comb begin
      status_word = '0;
      status_word[STAT_BUSY] = busy;
      status_word[STAT_FULL] = fifo_full;
      status_word[STAT_OVF]  = ovf;
      status_word[STAT_COUNT_LSB +: DEPTH_LOG2 + 1] = fifo_count;
   end

   // Bus response and sticky overflow; a drop beats a same-edge clear
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem_rdata <= '0;
         ovf       <= 1'b0;
      end else begin
         mem_rdata <= (sel_status && !mem_write) ? status_word : '0;
         if (drop)
            ovf <= 1'b1;
         else if (ovf_clr)
            ovf <= 1'b0;
      end
   end

   // Transmit FSM; tx is registered from the current state, so the line
   // trails the state by one cycle uniformly for every bit.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= ST_IDLE;
         baud    <= '0;
         bit_idx <= '0;
         tx      <= 1'b1;
      end else begin
         case (state)
            ST_START: tx <= 1'b0;
            ST_DATA:  tx <= shift[0];
            default:  tx <= 1'b1;
         endcase

         case (state)
            ST_IDLE: begin
               if (pop) begin
                  state <= ST_START;
                  baud  <= BAUD_RELOAD;
               end
            end
            ST_START: begin
               if (baud_zero) begin
                  baud    <= BAUD_RELOAD;
                  bit_idx <= '0;
                  state   <= ST_DATA;
               end else begin
                  baud <= baud - 1'b1;
               end
            end
            ST_DATA: begin
               if (baud_zero) begin
                  baud <= BAUD_RELOAD;
                  if (bit_idx == 3'd7)
                     state <= ST_STOP;
                  else
                     bit_idx <= bit_idx + 1'b1;
               end else begin
                  baud <= baud - 1'b1;
               end
            end
            default: begin
               if (baud_zero) begin
                  if (pop) begin
                     state <= ST_START;
                     baud  <= BAUD_RELOAD;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  baud <= baud - 1'b1;
               end
            end
         endcase
      end
   end

   // Shift register holds payload only; no reset needed
   always_ff @(posedge clk) begin
      if (pop)
         shift <= fifo_rdata;
      else if ((state == ST_DATA) && baud_zero)
         shift <= {1'b0, shift[7:1]};
   end

endmodule
